// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, drives the synchronous ROM address
// every cycle, and queues returned words with their PCs in a 2-entry FIFO
// toward decode. Redirects from execute restart fetch with a one-cycle
// address bypass so the target word is requested in the redirect cycle.
module ifetch #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // Request side: next PC to issue and the request whose word returns this cycle
  logic [31:0] fetch_pc_reg;
  logic [31:0] req_pc_reg;
  logic        req_valid_reg;

  // Queue bookkeeping
  logic [1:0]  count_reg;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;

  // Per-slot contents gathered for the head read mux
  logic [31:0]           entry_pc   [2];
  logic [DATA_WIDTH-1:0] entry_word [2];

  logic        pop;
  logic        push;
  logic        replay;
  logic        issue;
  logic [2:0]  occupancy;
  logic [31:0] redirect_pc_aligned;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake, credit and address decisions for the current cycle
  always_comb begin
    redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
    // The redirect target goes straight to the ROM so its word returns next cycle
    rom_addr    = redirect_valid ? redirect_pc[ADDR_WIDTH+1:2]
                                 : fetch_pc_reg[ADDR_WIDTH+1:2];
    instr_valid = (count_reg != 2'd0) && !redirect_valid;
    pop         = instr_valid && instr_ready;
    push        = req_valid_reg && rom_rdata_valid && !redirect_valid;
    replay      = req_valid_reg && !rom_rdata_valid;
    // Queued words plus the one in flight, less what leaves now; issuing only
    // below two guarantees every returning word has a free slot
    occupancy   = {1'b0, count_reg} + {2'b00, req_valid_reg} - {2'b00, pop};
    issue       = redirect_valid || (occupancy < 3'd2);
  end

  // PC and in-flight request tracking; redirect beats replay beats normal issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg  <= RESET_PC_ALIGNED;
      req_pc_reg    <= 32'd0;
      req_valid_reg <= 1'b0;
    end else if (redirect_valid) begin
      req_valid_reg <= 1'b1;
      req_pc_reg    <= redirect_pc_aligned;
      fetch_pc_reg  <= redirect_pc_aligned + 32'd4;
    end else if (replay) begin
      // Unqualified word: rewind so the same PC is requested again
      fetch_pc_reg  <= req_pc_reg;
      req_valid_reg <= 1'b0;
    end else if (issue) begin
      req_valid_reg <= 1'b1;
      req_pc_reg    <= fetch_pc_reg;
      fetch_pc_reg  <= fetch_pc_reg + 32'd4;
    end else begin
      // The word the ROM reads this cycle is simply not tracked
      req_valid_reg <= 1'b0;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (redirect_valid) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic SLOT = (gi == 1);
      logic [31:0]           pc_reg;
      logic [DATA_WIDTH-1:0] word_reg;

      // Slot storage: written when the returning word lands on this slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_reg   <= 32'd0;
          word_reg <= '0;
        end else if (push && (wr_ptr_reg == SLOT)) begin
          pc_reg   <= req_pc_reg;
          word_reg <= rom_rdata;
        end
      end

      assign entry_pc[gi]   = pc_reg;
      assign entry_word[gi] = word_reg;
    end
  endgenerate

  assign instr    = entry_word[rd_ptr_reg];
  assign instr_pc = entry_pc[rd_ptr_reg];

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a synchronous ROM model, directed bring-up/stall/redirect/
// replay/reset/wrap scenarios, then randomized traffic. A stream model checks
// that decode sees consecutive PCs from each restart point with the ROM word
// for that PC, in order, exactly once.
module tb_ifetch;

  localparam int          DW       = 32;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata = '0;
  logic          rom_rdata_valid;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;

  logic [DW-1:0] rom_mem [1 << AW];
  logic [AW-1:0] rom_q_addr = '0;
  logic          rand_valid = 1'b1;
  logic          drop_req = 1'b0;
  logic          drop_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int xfers = 0;

  ifetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rom_rdata_valid(rom_rdata_valid), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // ROM model: registered read; one response from word 3 can be marked invalid
  assign rom_rdata_valid = rand_valid && !(drop_req && !drop_done && rom_q_addr == 10'd3);
  always @(posedge clk) begin
    rom_rdata  <= rom_mem[rom_addr];
    rom_q_addr <= rom_addr;
    if (drop_req && !drop_done && rom_q_addr == 10'd3) drop_done <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model sampled on the falling edge
  task automatic monitor();
    logic [31:0] exp_pc = {RESET_PC[31:2], 2'b00};
    logic        prev_stall = 1'b0;
    logic        prev_redir = 1'b0;
    logic [31:0] last_pc = 32'd0;
    logic [DW-1:0] last_instr = '0;
    logic [AW-1:0] reset_idx = RESET_PC[AW+1:2];
    logic [31:0] rp;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", 64'(instr_pc), 64'd0);
        check("rst_addr", 64'(rom_addr), 64'(reset_idx));
        exp_pc = {RESET_PC[31:2], 2'b00};
        prev_stall = 1'b0;
        prev_redir = 1'b0;
      end else if (redirect_valid) begin
        rp = redirect_pc;
        check("redir_valid_low", 64'(instr_valid), 64'd0);
        check("redir_addr", 64'(rom_addr), 64'((rp >> 2) % (1 << AW)));
        exp_pc = rp - (rp % 4);
        prev_redir = 1'b1;
        prev_stall = 1'b0;
      end else begin
        if (prev_redir) check("post_redir_low", 64'(instr_valid), 64'd0);
        if (prev_stall) begin
          check("hold_valid", 64'(instr_valid), 64'd1);
          check("hold_pc", 64'(instr_pc), 64'(last_pc));
          check("hold_instr", 64'(instr), 64'(last_instr));
        end
        if (instr_valid && instr_ready) begin
          check("xfer_pc", 64'(instr_pc), 64'(exp_pc));
          check("xfer_instr", 64'(instr), 64'(rom_mem[(exp_pc >> 2) % (1 << AW)]));
          exp_pc = exp_pc + 32'd4;
          xfers++;
        end
        prev_stall = instr_valid && !instr_ready;
        prev_redir = 1'b0;
        last_pc = instr_pc;
        last_instr = instr;
      end
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    #1;
    check("redir_bypass_addr", 64'(rom_addr), 64'((pc >> 2) % (1 << AW)));
    check("redir_cycle_valid", 64'(instr_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_r1_valid", 64'(instr_valid), 64'd0);
  endtask

  initial begin
    int base_xfers;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = $urandom;
    rom_mem[0]  = 32'h0190_6093;
    rom_mem[1]  = 32'h02c0_6113;
    rom_mem[2]  = 32'h0000_01b3;
    rom_mem[10] = 32'h0000_006f;

    #1 rst = 1'b1;
    fork monitor(); join_none
    repeat (3) tick();
    check("reset_valid", 64'(instr_valid), 64'd0);
    check("reset_addr", 64'(rom_addr), 64'd0);
    rst = 1'b0;

    // Bring-up: two-cycle latency, then back-to-back words
    tick();
    check("lat_e0_valid", 64'(instr_valid), 64'd0);
    tick();
    check("lat_e1_valid", 64'(instr_valid), 64'd1);
    check("boot_pc0", 64'(instr_pc), 64'd0);
    check("boot_w0", 64'(instr), 64'h0190_6093);
    tick();
    check("boot_pc4", 64'(instr_pc), 64'd4);
    check("boot_w1", 64'(instr), 64'h02c0_6113);
    tick();
    check("boot_pc8", 64'(instr_pc), 64'd8);
    check("boot_w2", 64'(instr), 64'h0000_01b3);

    // Five-cycle decode stall at PC 8: head holds, fetch stops at word 4
    instr_ready = 1'b0;
    repeat (5) begin
      #1;
      check("stall_pc", 64'(instr_pc), 64'd8);
      check("stall_instr", 64'(instr), 64'h0000_01b3);
      check("stall_addr", 64'(rom_addr), 64'd4);
      tick();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("release_valid", 64'(instr_valid), 64'd1);
      check("release_pc", 64'(instr_pc), 64'(8 + 4 * k));
      tick();
    end

    // Redirect in free flow
    pulse_redirect(32'h0000_002B);
    tick();
    check("redir_flow_valid", 64'(instr_valid), 64'd1);
    check("redir_flow_pc", 64'(instr_pc), 64'h28);
    check("redir_flow_instr", 64'(instr), 64'h0000_006f);
    repeat (3) tick();

    // Redirect during a stall
    instr_ready = 1'b0;
    repeat (3) tick();
    pulse_redirect(32'h0000_002B);
    tick();
    check("redir_stall_valid", 64'(instr_valid), 64'd1);
    check("redir_stall_pc", 64'(instr_pc), 64'h28);
    check("redir_stall_instr", 64'(instr), 64'h0000_006f);
    instr_ready = 1'b1;
    repeat (3) tick();

    // One invalid ROM response for PC 12: must be refetched exactly once
    pulse_redirect(32'h0000_0000);
    drop_req = 1'b1;
    repeat (12) tick();

    // Asynchronous reset with the queue full
    instr_ready = 1'b0;
    repeat (2) tick();
    check("pre_rst_valid", 64'(instr_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(instr_valid), 64'd0);
    check("async_rst_instr", 64'(instr), 64'd0);
    check("async_rst_pc", 64'(instr_pc), 64'd0);
    check("async_rst_addr", 64'(rom_addr), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("restart_e0_valid", 64'(instr_valid), 64'd0);
    tick();
    check("restart_valid", 64'(instr_valid), 64'd1);
    check("restart_pc", 64'(instr_pc), 64'd0);

    // ROM address wrap at the top of the word space
    pulse_redirect(32'h0000_0FFC);
    check("wrap_addr", 64'(rom_addr), 64'd0);
    tick();
    check("wrap_pc_top", 64'(instr_pc), 64'h0FFC);
    tick();
    check("wrap_pc_full", 64'(instr_pc), 64'h1000);
    check("wrap_instr", 64'(instr), 64'(rom_mem[0]));

    // Randomized traffic
    base_xfers = xfers;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      rand_valid  = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      tick();
    end
    redirect_valid = 1'b0;
    rand_valid = 1'b1;
    instr_ready = 1'b1;
    repeat (5) tick();
    check("rand_progress", 64'(xfers - base_xfers > 500), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
